// File: rtl/branch_update_queue_if.sv
// Handshake bundle between the branch-resolution producer, the update queue and the predictor
// training port. The master drives the queue's inputs; the slave is the queue itself.
interface branch_update_queue_if;
    logic        enq_valid;
    logic        enq_ready;
    logic [63:0] enq_pc;
    logic        enq_taken;
    logic [63:0] enq_target;
    logic        hold;
    logic        flush;
    logic        update_valid;
    logic [63:0] update_pc;
    logic        update_taken;
    logic [63:0] update_target;

    modport master (
        output enq_valid, enq_pc, enq_taken, enq_target, hold, flush,
        input  enq_ready, update_valid, update_pc, update_taken, update_target
    );

    modport slave (
        input  enq_valid, enq_pc, enq_taken, enq_target, hold, flush,
        output enq_ready, update_valid, update_pc, update_taken, update_target
    );
endinterface

// File: rtl/branch_update_queue.sv
// Circular queue of resolved branches, drained one per cycle into the predictor training port,
// with drain hold, full flush and free-running update statistics.
module branch_update_queue #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    branch_update_queue_if.slave     bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         stat_updates,
    output logic [CNT_W-1:0]         stat_taken
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [63:0] pc;
        logic        taken;
        logic [63:0] target;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             enq_fire;
    logic             deq_fire;

    // Ready depends on registered occupancy only: a full queue refuses even when draining.
    assign bus.enq_ready = (count != FULL);
    assign enq_fire      = bus.enq_valid && bus.enq_ready && !bus.flush;
    assign deq_fire      = (count != '0) && !bus.hold && !bus.flush && !rst;

    assign head              = mem[rd_ptr];
    assign bus.update_valid  = deq_fire;
    assign bus.update_pc     = (count != '0) ? head.pc     : '0;
    assign bus.update_taken  = (count != '0) ? head.taken  : 1'b0;
    assign bus.update_target = (count != '0) ? head.target : '0;

    // NOTE: storage has no reset; occupancy and pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            mem[wr_ptr] <= '{pc: bus.enq_pc, taken: bus.enq_taken, target: bus.enq_target};
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (bus.flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq_fire) wr_ptr <= wr_ptr + 1'b1;
            if (deq_fire) rd_ptr <= rd_ptr + 1'b1;
            case ({enq_fire, deq_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Statistics survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_updates <= '0;
            stat_taken   <= '0;
        end else if (deq_fire) begin
            stat_updates <= stat_updates + 1'b1;
            stat_taken   <= stat_taken + CNT_W'(head.taken);
        end
    end
endmodule

// File: tb/tb_branch_update_queue.sv
// Directed self-checking bench for branch_update_queue (DEPTH=8, CNT_W=32).
module tb_branch_update_queue;
    logic        clk;
    logic        rst;
    logic [3:0]  count;
    logic [31:0] stat_updates;
    logic [31:0] stat_taken;
    int          checks;
    int          failures;

    branch_update_queue_if bus ();

    branch_update_queue #(.DEPTH(8), .CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .count        (count),
        .stat_updates (stat_updates),
        .stat_taken   (stat_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] pc, input logic tk, input logic [63:0] tg);
        bus.enq_valid  = v;
        bus.enq_pc     = pc;
        bus.enq_taken  = tk;
        bus.enq_target = tg;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},   64'(bus.enq_ready), 64'd1);
        check({tag, "_uvalid"},  64'(bus.update_valid), 64'd0);
        check({tag, "_upc"},     bus.update_pc, 64'd0);
        check({tag, "_utaken"},  64'(bus.update_taken), 64'd0);
        check({tag, "_utarget"}, bus.update_target, 64'd0);
        check({tag, "_count"},   64'(count), 64'd0);
        check({tag, "_stat_u"},  64'(stat_updates), 64'd0);
        check({tag, "_stat_t"},  64'(stat_taken), 64'd0);
    endtask

    initial begin
        int next_in;
        int next_out;
        checks   = 0;
        failures = 0;
        rst       = 1'b1;
        bus.hold  = 1'b0;
        bus.flush = 1'b0;
        drive(1'b0, 64'd0, 1'b0, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        settle();
        check_reset_outputs("rst0");

        // Single enqueue: invisible in its own cycle, issued the next.
        drive(1'b1, 64'h1000, 1'b1, 64'h2000);
        settle();
        check("single_early_valid", 64'(bus.update_valid), 64'd0);
        tick();
        drive(1'b0, 64'd0, 1'b0, 64'd0);
        settle();
        check("single_valid",  64'(bus.update_valid), 64'd1);
        check("single_pc",     bus.update_pc, 64'h1000);
        check("single_taken",  64'(bus.update_taken), 64'd1);
        check("single_target", bus.update_target, 64'h2000);
        check("single_count1", 64'(count), 64'd1);
        tick();
        settle();
        check("single_count0", 64'(count), 64'd0);
        check("single_stat_u", 64'(stat_updates), 64'd1);
        check("single_stat_t", 64'(stat_taken), 64'd1);

        // Hold: nine back-to-back enqueues, the ninth refused.
        bus.hold = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 64'h3000 + 64'(i * 4), i[0], 64'h9000 + 64'(i));
            settle();
            check("hold_ready", 64'(bus.enq_ready), (i < 8) ? 64'd1 : 64'd0);
            check("hold_no_update", 64'(bus.update_valid), 64'd0);
            if (i == 8) check("hold_count_full", 64'(count), 64'd8);
            tick();
        end
        drive(1'b0, 64'd0, 1'b0, 64'd0);
        bus.hold = 1'b0;
        for (int i = 0; i < 8; i++) begin
            settle();
            check("drain_valid",  64'(bus.update_valid), 64'd1);
            check("drain_pc",     bus.update_pc, 64'h3000 + 64'(i * 4));
            check("drain_taken",  64'(bus.update_taken), 64'(i[0]));
            check("drain_target", bus.update_target, 64'h9000 + 64'(i));
            tick();
        end
        settle();
        check("drain_count0", 64'(count), 64'd0);
        check("drain_stat_u", 64'(stat_updates), 64'd9);
        check("drain_stat_t", 64'(stat_taken), 64'd5);

        // Full queue with enq_valid held while draining.
        bus.hold = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 64'h4000 + 64'(i * 8), 1'b0, 64'd0);
            tick();
        end
        bus.hold = 1'b0;
        drive(1'b1, 64'h4000 + 64'(8 * 8), 1'b0, 64'd0);
        settle();
        check("full_c1_ready", 64'(bus.enq_ready), 64'd0);
        check("full_c1_valid", 64'(bus.update_valid), 64'd1);
        check("full_c1_pc",    bus.update_pc, 64'h4000);
        tick();
        check("full_c1_count", 64'(count), 64'd7);
        settle();
        check("full_c2_ready", 64'(bus.enq_ready), 64'd1);
        check("full_c2_valid", 64'(bus.update_valid), 64'd1);
        check("full_c2_pc",    bus.update_pc, 64'h4008);
        tick();
        check("full_c2_count", 64'(count), 64'd7);
        drive(1'b0, 64'd0, 1'b0, 64'd0);
        for (int i = 2; i < 9; i++) begin
            settle();
            check("full_drain_valid", 64'(bus.update_valid), 64'd1);
            check("full_drain_pc",    bus.update_pc, 64'h4000 + 64'(i * 8));
            tick();
        end
        settle();
        check("full_count0", 64'(count), 64'd0);
        check("full_stat_u", 64'(stat_updates), 64'd18);
        check("full_stat_t", 64'(stat_taken), 64'd5);

        // Wrap-around stream of 20 entries with hold toggling every 3 cycles.
        next_in  = 0;
        next_out = 0;
        for (int cyc = 0; cyc < 200 && next_out < 20; cyc++) begin
            bus.hold = ((cyc / 3) % 2) == 1;
            if (next_in < 20)
                drive(1'b1, 64'h100 * 64'(next_in), (next_in % 3) == 0, 64'h8000 + 64'(next_in));
            else
                drive(1'b0, 64'd0, 1'b0, 64'd0);
            settle();
            if (bus.hold) check("wrap_hold_quiet", 64'(bus.update_valid), 64'd0);
            if (bus.update_valid) begin
                check("wrap_pc",    bus.update_pc, 64'h100 * 64'(next_out));
                check("wrap_taken", 64'(bus.update_taken), 64'((next_out % 3) == 0));
                next_out++;
            end
            if (bus.enq_valid && bus.enq_ready) next_in++;
            tick();
        end
        drive(1'b0, 64'd0, 1'b0, 64'd0);
        bus.hold = 1'b0;
        settle();
        check("wrap_all_out", 64'(next_out), 64'd20);
        check("wrap_stat_u",  64'(stat_updates), 64'd38);
        check("wrap_stat_t",  64'(stat_taken), 64'd12);

        // Flush with five queued entries and a simultaneous enqueue.
        bus.hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 64'h5000 + 64'(i), 1'b1, 64'd0);
            tick();
        end
        bus.hold  = 1'b0;
        bus.flush = 1'b1;
        drive(1'b1, 64'h6000, 1'b1, 64'd0);
        settle();
        check("flush_count5", 64'(count), 64'd5);
        check("flush_valid",  64'(bus.update_valid), 64'd0);
        tick();
        bus.flush = 1'b0;
        drive(1'b0, 64'd0, 1'b0, 64'd0);
        settle();
        check("flush_count0", 64'(count), 64'd0);
        check("flush_ready",  64'(bus.enq_ready), 64'd1);
        check("flush_uvalid", 64'(bus.update_valid), 64'd0);
        check("flush_upc",    bus.update_pc, 64'd0);
        check("flush_stat_u", 64'(stat_updates), 64'd38);
        check("flush_stat_t", 64'(stat_taken), 64'd12);
        drive(1'b1, 64'h7000, 1'b0, 64'h7100);
        tick();
        drive(1'b0, 64'd0, 1'b0, 64'd0);
        settle();
        check("post_flush_valid", 64'(bus.update_valid), 64'd1);
        check("post_flush_pc",    bus.update_pc, 64'h7000);
        tick();

        // Reset mid-drain with four entries queued.
        bus.hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 64'hA000 + 64'(i), 1'b1, 64'd0);
            tick();
        end
        drive(1'b0, 64'd0, 1'b0, 64'd0);
        bus.hold = 1'b0;
        tick();
        settle();
        check("rst_mid_count4", 64'(count), 64'd4);
        rst = 1'b1;
        settle();
        check("rst_cycle_valid", 64'(bus.update_valid), 64'd0);
        tick();
        rst = 1'b0;
        settle();
        check_reset_outputs("rst_mid");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
